// File: rtl/baccarat_controller.sv
// rtl/baccarat_controller.sv - Moore FSM sequencing one baccarat game over the datapath
//
// Ports:
//   slow_clock        game clock, state advances on rising edge
//   resetb            asynchronous active-low reset
//   pscore, dscore    player / dealer totals 0-9 from the datapath
//   pcard3            player third card rank (0 = none, 1-13 = A..K)
//   load_pcard1..3    one-hot strobes: capture player cards
//   load_dcard1..3    one-hot strobes: capture dealer cards
//   player_win_light  player wins or tie
//   dealer_win_light  dealer wins or tie
//   done              game finished, lights valid
module baccarat_controller (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic       done
);

    typedef enum logic [3:0] {
        S_START = 4'd0,
        S_P1    = 4'd1,
        S_D1    = 4'd2,
        S_P2    = 4'd3,
        S_D2    = 4'd4,
        S_EVAL  = 4'd5,
        S_P3    = 4'd6,
        S_DEVAL = 4'd7,
        S_D3    = 4'd8,
        S_DONE  = 4'd9
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [3:0] pv;
    logic       dealer_draws;

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state <= S_START;
        end else begin
            state <= next_state;
        end
    end

    // Face cards and tens count as zero toward the dealer's third-card rule.
    always_comb begin
        pv = (pcard3 >= 4'd10) ? 4'd0 : pcard3;
        dealer_draws = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: dealer_draws = 1'b1;
            4'd3:             dealer_draws = (pv != 4'd8);
            4'd4:             dealer_draws = (pv >= 4'd2) && (pv <= 4'd7);
            4'd5:             dealer_draws = (pv >= 4'd4) && (pv <= 4'd7);
            4'd6:             dealer_draws = (pv >= 4'd6) && (pv <= 4'd7);
            default:          dealer_draws = 1'b0;
        endcase
    end

    always_comb begin
        next_state = S_START;
        case (state)
            S_START: next_state = S_P1;
            S_P1:    next_state = S_D1;
            S_D1:    next_state = S_P2;
            S_P2:    next_state = S_D2;
            S_D2:    next_state = S_EVAL;
            // Out-of-range scores (>9) fall into the natural branch.
            S_EVAL: begin
                if ((pscore >= 4'd8) || (dscore >= 4'd8)) begin
                    next_state = S_DONE;
                end else if (pscore <= 4'd5) begin
                    next_state = S_P3;
                end else if (dscore <= 4'd5) begin
                    next_state = S_D3;
                end else begin
                    next_state = S_DONE;
                end
            end
            S_P3:    next_state = S_DEVAL;
            S_DEVAL: next_state = dealer_draws ? S_D3 : S_DONE;
            S_D3:    next_state = S_DONE;
            S_DONE:  next_state = S_DONE;
            default: next_state = S_START;
        endcase
    end

    // Lights are captured on every edge that lands in S_DONE; scores are
    // frozen there, so the value is stable for the rest of the game.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            player_win_light <= 1'b0;
            dealer_win_light <= 1'b0;
        end else if (next_state == S_DONE) begin
            player_win_light <= (pscore >= dscore);
            dealer_win_light <= (dscore >= pscore);
        end else begin
            player_win_light <= 1'b0;
            dealer_win_light <= 1'b0;
        end
    end

    assign load_pcard1 = (state == S_P1);
    assign load_dcard1 = (state == S_D1);
    assign load_pcard2 = (state == S_P2);
    assign load_dcard2 = (state == S_D2);
    assign load_pcard3 = (state == S_P3);
    assign load_dcard3 = (state == S_D3);
    assign done        = (state == S_DONE);

endmodule

// File: tb/tb_baccarat_controller.sv
// tb/tb_baccarat_controller.sv - scoreboard bench for baccarat_controller
module tb_baccarat_controller;

    logic       slow_clock = 1'b0;
    logic       resetb = 1'b0;
    logic [3:0] pscore = 4'd0;
    logic [3:0] dscore = 4'd0;
    logic [3:0] pcard3 = 4'd0;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light, done;

    int errors = 0;
    int checks = 0;

    // {lp1, ld1, lp2, ld2, lp3, ld3, pwin, dwin, done}
    logic [8:0] obs;
    logic [8:0] exp_q[$];

    localparam logic [8:0] O_IDLE = 9'b000000000;
    localparam logic [8:0] O_P1   = 9'b100000000;
    localparam logic [8:0] O_D1   = 9'b010000000;
    localparam logic [8:0] O_P2   = 9'b001000000;
    localparam logic [8:0] O_D2   = 9'b000100000;
    localparam logic [8:0] O_P3   = 9'b000010000;
    localparam logic [8:0] O_D3   = 9'b000001000;

    assign obs = {load_pcard1, load_dcard1, load_pcard2, load_dcard2,
                  load_pcard3, load_dcard3, player_win_light, dealer_win_light, done};

    baccarat_controller dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .done             (done)
    );

    always #5 slow_clock = ~slow_clock;

    task automatic check_val(input string tag, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic bit model_draw(input logic [3:0] ds, input logic [3:0] pc3);
        int v;
        v = (pc3 >= 10) ? 0 : int'(pc3);
        if (ds <= 2)  return 1'b1;
        if (ds == 3)  return v != 8;
        if (ds == 4)  return v >= 2 && v <= 7;
        if (ds == 5)  return v >= 4 && v <= 7;
        if (ds == 6)  return v == 6 || v == 7;
        return 1'b0;
    endfunction

    // Expected per-cycle outputs for one game, starting at the first edge after reset release.
    task automatic build_expect(input logic [3:0] ps, input logic [3:0] ds, input logic [3:0] pc3,
                                input logic [3:0] ps3, input logic [3:0] ds3);
        logic [3:0] psf, dsf;
        logic [8:0] fin;
        psf = ps;
        dsf = ds;
        exp_q.delete();
        exp_q.push_back(O_P1);
        exp_q.push_back(O_D1);
        exp_q.push_back(O_P2);
        exp_q.push_back(O_D2);
        exp_q.push_back(O_IDLE);
        if (ps >= 8 || ds >= 8) begin
        end else if (ps <= 5) begin
            exp_q.push_back(O_P3);
            exp_q.push_back(O_IDLE);
            psf = ps3;
            if (model_draw(ds, pc3)) begin
                exp_q.push_back(O_D3);
                dsf = ds3;
            end
        end else if (ds <= 5) begin
            exp_q.push_back(O_D3);
            dsf = ds3;
        end
        fin = {6'b0, psf >= dsf, dsf >= psf, 1'b1};
        for (int i = 0; i < 3; i++) exp_q.push_back(fin);
    endtask

    // Datapath stand-in: scores change on the falling edge of the strobe cycle.
    task automatic run_game(input string name, input logic [3:0] ps, input logic [3:0] ds,
                            input logic [3:0] pc3, input logic [3:0] ps3, input logic [3:0] ds3,
                            input bit abort_p3);
        logic [8:0] e;
        build_expect(ps, ds, pc3, ps3, ds3);
        resetb = 1'b0;
        pscore = 4'd0;
        dscore = 4'd0;
        pcard3 = 4'd0;
        @(negedge slow_clock);
        check_val({name, ":reset"}, obs, O_IDLE);
        resetb = 1'b1;
        #1 check_val({name, ":start"}, obs, O_IDLE);
        while (exp_q.size() > 0) begin
            @(posedge slow_clock);
            #1;
            e = exp_q.pop_front();
            check_val({name, ":seq"}, obs, e);
            if (abort_p3 && e[4]) begin
                #2 resetb = 1'b0;
                #1 check_val({name, ":midreset"}, obs, O_IDLE);
                exp_q.delete();
            end else begin
                @(negedge slow_clock);
                if (e[5]) begin
                    pscore = ps;
                    dscore = ds;
                end
                if (e[4]) begin
                    pcard3 = pc3;
                    pscore = ps3;
                end
                if (e[3]) dscore = ds3;
            end
        end
    endtask

    initial begin
        logic [3:0] pv;
        #2 check_val("por", obs, O_IDLE);
        run_game("natural",   4'd8, 4'd3, 4'd0,  4'd8, 4'd3, 1'b0);
        run_game("p3_stand",  4'd4, 4'd7, 4'd13, 4'd4, 4'd7, 1'b0);
        run_game("d3_pv8",    4'd2, 4'd3, 4'd8,  4'd0, 4'd3, 1'b0);
        run_game("d3_pv7",    4'd2, 4'd3, 4'd7,  4'd9, 4'd5, 1'b0);
        run_game("banker_d3", 4'd6, 4'd5, 4'd0,  4'd6, 4'd6, 1'b0);
        run_game("stand_67",  4'd6, 4'd7, 4'd0,  4'd6, 4'd7, 1'b0);
        run_game("oor_score", 4'd12, 4'd0, 4'd0, 4'd12, 4'd0, 1'b0);
        for (int d = 0; d < 8; d++) begin
            for (int c = 0; c < 14; c++) begin
                pv = (c >= 10) ? 4'd0 : 4'(c);
                run_game($sformatf("sweep_d%0d_c%0d", d, c), 4'd0, 4'(d), 4'(c),
                         pv, 4'((d + 1) % 10), 1'b0);
            end
        end
        run_game("abort_p3",  4'd2, 4'd3, 4'd7,  4'd9, 4'd5, 1'b1);
        run_game("restart",   4'd8, 4'd3, 4'd0,  4'd8, 4'd3, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
